lvds_input_axi_write: RTL and testbench

LVDS_INPUT_AXI_WRITE -- requirements
Module: lvds_input_axi_write

---
 rtl/lvds_input_axi_write.sv | 157 +++++++++++++++
 tb/tb_lvds_input_axi_write.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lvds_input_axi_write.sv
// AXI4-Lite write-only slave for the LVDS input control registers (CR, SR, DSIZE).
// Define LVDS_INPUT_WSTRB_EN to honour WSTRB byte lanes; otherwise every write is full 32-bit.
module lvds_input_axi_write #(
    parameter logic [31:0] DSIZE_RESET = 32'd4096
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        cr_test,
    output logic        cr_rt,
    output logic [31:0] dsize,
    output logic        sr_pc_clr
);
    typedef enum logic [2:0] {IDLE, GOT_A, GOT_W, WRITE, RESP} state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        cr_test_q, cr_test_d;
    logic        cr_rt_q, cr_rt_d;
    logic [31:0] dsize_q, dsize_d;
    logic        sr_pc_clr_q, sr_pc_clr_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;

    logic        aw_hs, w_hs;
    logic [3:0]  strb;
    logic [31:0] merged;
    logic        unused_addr;

    assign unused_addr = ^AWADDR[31:8];

`ifdef LVDS_INPUT_WSTRB_EN
    assign strb = wstrb_q;
`else
    logic unused_wstrb;
    assign strb         = 4'hF;
    assign unused_wstrb = ^wstrb_q;
`endif

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;

    // DSIZE candidate: old value with the enabled byte lanes replaced
    always_comb begin
        merged = dsize_q;
        for (int i = 0; i < 4; i++)
            if (strb[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cr_test_d   = cr_test_q;
        cr_rt_d     = cr_rt_q;
        dsize_d     = dsize_q;
        sr_pc_clr_d = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;

        if (aw_hs) awaddr_d = AWADDR[7:0];
        if (w_hs) begin
            wdata_d = WDATA;
            wstrb_d = WSTRB;
        end

        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) state_d = WRITE;
                else if (aw_hs)    state_d = GOT_A;
                else if (w_hs)     state_d = GOT_W;
            end
            GOT_A: if (w_hs)  state_d = WRITE;
            GOT_W: if (aw_hs) state_d = WRITE;
            WRITE: begin
                state_d  = RESP;
                bvalid_d = 1'b1;
                bresp_d  = OKAY;
                case (awaddr_q)
                    8'h00: if (strb[0]) {cr_rt_d, cr_test_d} = wdata_q[1:0];
                    8'h04: sr_pc_clr_d = strb[0] && wdata_q[0];
                    8'h08: begin
                        if (merged == 32'd0) bresp_d = SLVERR;
                        else                 dsize_d = merged;
                    end
                    default: bresp_d = SLVERR;
                endcase
            end
            RESP: begin
                if (BREADY) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE) || (state_d == GOT_W);
        wready_d  = (state_d == IDLE) || (state_d == GOT_A);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cr_test_q   <= 1'b0;
            cr_rt_q     <= 1'b0;
            dsize_q     <= DSIZE_RESET;
            sr_pc_clr_q <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cr_test_q   <= cr_test_d;
            cr_rt_q     <= cr_rt_d;
            dsize_q     <= dsize_d;
            sr_pc_clr_q <= sr_pc_clr_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign cr_test   = cr_test_q;
    assign cr_rt     = cr_rt_q;
    assign dsize     = dsize_q;
    assign sr_pc_clr = sr_pc_clr_q;
endmodule

// File: tb/tb_lvds_input_axi_write.sv
// Directed bench for lvds_input_axi_write: inputs change on negedge, outputs checked on negedge.
module tb_lvds_input_axi_write;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        cr_test;
    logic        cr_rt;
    logic [31:0] dsize;
    logic        sr_pc_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    lvds_input_axi_write dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .cr_test(cr_test), .cr_rt(cr_rt), .dsize(dsize), .sr_pc_clr(sr_pc_clr)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) if (sr_pc_clr === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Both handshakes in one cycle, BREADY high; returns BRESP and checks 2-cycle latency.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
        int n;
        @(negedge ACLK);
        chk("ready_before_wr", {30'd0, AWREADY, WREADY}, 32'h3);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 1;
        while (BVALID !== 1'b1 && n < 10) begin
            @(negedge ACLK);
            n++;
        end
        chk("b_latency", n, 2);
        r = BRESP;
        @(negedge ACLK);
        chk("bvalid_drop", {31'd0, BVALID}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bvalid"}, {31'd0, BVALID}, 32'd0);
        chk({tag, "_bresp"}, {30'd0, BRESP}, 32'd0);
        chk({tag, "_cr"}, {30'd0, cr_rt, cr_test}, 32'd0);
        chk({tag, "_dsize"}, dsize, 32'd4096);
        chk({tag, "_pcclr"}, {31'd0, sr_pc_clr}, 32'd0);
        chk({tag, "_ready"}, {30'd0, AWREADY, WREADY}, 32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] r;
        int p0;
        ARESET = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = 4'hF;
        WVALID = 1'b0; BREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        check_reset_vals("rst");
        ARESET = 1'b0;

        // Same-cycle AW+W to CR, manual timing
        @(negedge ACLK);
        AWADDR = 32'h0; WDATA = 32'h3; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("cr_not_yet", {30'd0, cr_rt, cr_test}, 32'd0);
        chk("write_ready_low", {30'd0, AWREADY, WREADY}, 32'd0);
        @(negedge ACLK);
        chk("cr_loaded", {30'd0, cr_rt, cr_test}, 32'h3);
        chk("cr_bvalid", {31'd0, BVALID}, 32'd1);
        chk("cr_bresp", {30'd0, BRESP}, 32'd0);
        @(negedge ACLK);
        chk("cr_bvalid_1cyc", {31'd0, BVALID}, 32'd0);

        // DSIZE zero -> SLVERR, unmapped -> SLVERR
        wr(32'h08, 32'h0, 4'hF, r);
        chk("dsz0_resp", {30'd0, r}, 32'h2);
        chk("dsz0_keep", dsize, 32'd4096);
        wr(32'h1C, 32'hFFFF_FFFF, 4'hF, r);
        chk("unmap_resp", {30'd0, r}, 32'h2);
        chk("unmap_dsize", dsize, 32'd4096);
        chk("unmap_cr", {30'd0, cr_rt, cr_test}, 32'h3);
        // Upper address bits are not decoded: 0x100 aliases CR
        wr(32'h100, 32'h1, 4'hF, r);
        chk("alias_resp", {30'd0, r}, 32'h0);
        chk("alias_cr", {30'd0, cr_rt, cr_test}, 32'h1);

        // W first, AW 3 cycles later
        @(negedge ACLK);
        WDATA = 32'h1234; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        chk("gotw_ready", {30'd0, AWREADY, WREADY}, 32'h2);
        @(negedge ACLK);
        @(negedge ACLK);
        chk("gotw_hold", {30'd0, AWREADY, WREADY}, 32'h2);
        AWADDR = 32'h08; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("gotw_dsize_wait", dsize, 32'd4096);
        @(negedge ACLK);
        chk("gotw_dsize", dsize, 32'h1234);
        chk("gotw_bvalid", {31'd0, BVALID}, 32'd1);
        chk("gotw_bresp", {30'd0, BRESP}, 32'd0);
        @(negedge ACLK);

        // SR W1C with BREADY held low
        p0 = pulses;
        @(negedge ACLK);
        AWADDR = 32'h04; WDATA = 32'h1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("sr_no_pulse_yet", {31'd0, sr_pc_clr}, 32'd0);
        @(negedge ACLK);
        chk("sr_pulse", {31'd0, sr_pc_clr}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("sr_bvalid_hold", {31'd0, BVALID}, 32'd1);
            chk("sr_bresp_hold", {30'd0, BRESP}, 32'd0);
            chk("sr_resp_notready", {30'd0, AWREADY, WREADY}, 32'd0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        chk("sr_bvalid_drop", {31'd0, BVALID}, 32'd0);
        chk("sr_pulse_count", pulses - p0, 32'd1);
        wr(32'h04, 32'h0, 4'hF, r);
        chk("sr0_resp", {30'd0, r}, 32'h0);
        chk("sr0_no_pulse", pulses - p0, 32'd1);

        // Byte strobes on DSIZE
        wr(32'h08, 32'h1122_3344, 4'hF, r);
        chk("dsz_full", dsize, 32'h1122_3344);
        wr(32'h08, 32'hAABB_CCDD, 4'b0010, r);
        chk("dsz_strb_resp", {30'd0, r}, 32'h0);
`ifdef LVDS_INPUT_WSTRB_EN
        chk("dsz_strb", dsize, 32'h1122_CC44);
`else
        chk("dsz_strb", dsize, 32'hAABB_CCDD);
`endif
        wr(32'h00, 32'h2, 4'b0000, r);
        chk("cr_strb0_resp", {30'd0, r}, 32'h0);
`ifdef LVDS_INPUT_WSTRB_EN
        chk("cr_strb0", {30'd0, cr_rt, cr_test}, 32'h1);
`else
        chk("cr_strb0", {30'd0, cr_rt, cr_test}, 32'h2);
`endif

        // Reset while in GOT_A, then W after release
        @(negedge ACLK);
        AWADDR = 32'h00; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("gota_ready", {30'd0, AWREADY, WREADY}, 32'h1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check_reset_vals("midrst");
        WDATA = 32'h3; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_b", {31'd0, BVALID}, 32'd0);
            @(negedge ACLK);
        end
        chk("abort_cr", {30'd0, cr_rt, cr_test}, 32'd0);
        chk("abort_dsize", dsize, 32'd4096);
        chk("abort_gotw", {30'd0, AWREADY, WREADY}, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
